// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared types and helpers for the multi-digit countdown timer.
//   state_t    : controller states (IDLE, RUN, PAUSE, EXPIRED)
//   DIGIT_W    : width of one digit slice of count/preset
//   clampDigit : limits a loaded digit to the largest legal value for a radix
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  // A preset digit outside the radix would break the borrow chain (it would
  // count down through illegal codes), so it is pinned to radix-1 on load.
  function automatic logic [DIGIT_W-1:0] clampDigit(input logic [DIGIT_W-1:0] digit,
                                                    input int unsigned radix);
    logic [DIGIT_W-1:0] result;
    if (32'(digit) >= radix) begin
      result = DIGIT_W'(radix - 1);
    end else begin
      result = digit;
    end
    return result;
  endfunction

endpackage

// File: rtl/countdown_digit.sv
// countdown_digit
// One digit of the cascaded down counter.
//   clk, reset : system clock, asynchronous active-high reset (clears to 0)
//   i_load     : capture i_loadVal (wins over i_dec)
//   i_loadVal  : value to capture
//   i_dec      : decrement by one this cycle
//   i_wrap     : value taken when decrementing from 0 (radix-1)
//   o_value    : registered digit value
//   o_isZero   : digit currently 0, feeds the borrow chain
module countdown_digit
  import countdown_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_loadVal,
  input  logic               i_dec,
  input  logic [DIGIT_W-1:0] i_wrap,
  output logic [DIGIT_W-1:0] o_value,
  output logic               o_isZero
);

  logic [DIGIT_W-1:0] r_value;

  // Digit register: load has priority, a decrement from 0 wraps to radix-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_loadVal;
    end else if (i_dec) begin
      if (r_value == '0) begin
        r_value <= i_wrap;
      end else begin
        r_value <= r_value - DIGIT_W'(1);
      end
    end
  end

  assign o_value  = r_value;
  assign o_isZero = (r_value == '0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// Multi-digit down-counting timer driven by an external tick strobe.
//   clk, reset  : system clock, asynchronous active-high reset
//   tick        : one-cycle count strobe, honoured only while running
//   load        : capture preset into count and the reload register
//   preset      : per-digit preset, digit 0 in bits [3:0]
//   start, stop : begin/resume and pause counting
//   auto_reload : 1 = periodic, 0 = one-shot
//   count       : current value (registered)
//   running     : registered, high while in RUN
//   zero        : combinational count == 0
//   done        : registered one-cycle expiry pulse
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int RADIX  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    load,
  input  logic [DIGIT_W*DIGITS-1:0] preset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    auto_reload,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);

  localparam int W = DIGIT_W * DIGITS;

  state_t                 r_state;
  logic   [W-1:0]         r_reload;
  logic                   r_running;
  logic                   r_done;

  logic   [W-1:0]         w_count;
  logic   [W-1:0]         w_presetClamped;
  logic   [DIGITS-1:0]    w_digitZero;
  logic   [DIGITS-1:0]    w_lowerZero;
  logic                   w_tickQual;
  logic                   w_isOne;
  logic                   w_reloadNow;
  logic                   w_digitLoad;
  logic   [W-1:0]         w_digitLoadVal;

  // A tick only counts in RUN and when neither load nor stop claims the cycle.
  assign w_tickQual = (r_state == RUN) && tick && !load && !stop;
  assign w_isOne    = (w_count == W'(1));

  // On the expiring tick in periodic mode the digits reload instead of
  // decrementing; in one-shot mode the natural 1 -> 0 decrement is used.
  assign w_reloadNow    = w_tickQual && w_isOne && auto_reload;
  assign w_digitLoad    = load || w_reloadNow;
  assign w_digitLoadVal = load ? w_presetClamped : r_reload;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_presetClamped[gi*DIGIT_W +: DIGIT_W] =
        clampDigit(preset[gi*DIGIT_W +: DIGIT_W], RADIX);

      // Ripple borrow: a digit moves only when every lower digit is 0.
      if (gi == 0) begin : g_first
        assign w_lowerZero[gi] = 1'b1;
      end else begin : g_rest
        assign w_lowerZero[gi] = w_lowerZero[gi-1] && w_digitZero[gi-1];
      end

      countdown_digit u_digit (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_digitLoad),
        .i_loadVal (w_digitLoadVal[gi*DIGIT_W +: DIGIT_W]),
        .i_dec     (w_tickQual && w_lowerZero[gi]),
        .i_wrap    (DIGIT_W'(RADIX - 1)),
        .o_value   (w_count[gi*DIGIT_W +: DIGIT_W]),
        .o_isZero  (w_digitZero[gi])
      );
    end
  endgenerate

  // Controller: state, reload register and the registered running/done
  // outputs. running is written alongside every state change so it always
  // mirrors the state after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_reload  <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_reload  <= w_presetClamped;
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!stop && start && !zero) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end else if (w_tickQual && w_isOne) begin
              r_done <= 1'b1;
              if (!auto_reload) begin
                r_state   <= EXPIRED;
                r_running <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (!stop && start) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= EXPIRED;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = w_count;
  assign zero    = (w_count == '0);
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Directed bench for countdown_timer: a 3-digit BCD instance for most
// scenarios and a 1-digit hex instance for the full-range radix case.
module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        tick, load, start, stop, autoReload;
  logic [11:0] preset;
  logic [11:0] count;
  logic        running, zero, done;

  logic        tickB, loadB, startB, stopB, autoReloadB;
  logic [3:0]  presetB;
  logic [3:0]  countB;
  logic        runningB, zeroB, doneB;

  int checks;
  int failures;

  countdown_timer #(.DIGITS(3), .RADIX(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .load        (load),
    .preset      (preset),
    .start       (start),
    .stop        (stop),
    .auto_reload (autoReload),
    .count       (count),
    .running     (running),
    .zero        (zero),
    .done        (done)
  );

  countdown_timer #(.DIGITS(1), .RADIX(16)) dutHex (
    .clk         (clk),
    .reset       (reset),
    .tick        (tickB),
    .load        (loadB),
    .preset      (presetB),
    .start       (startB),
    .stop        (stopB),
    .auto_reload (autoReloadB),
    .count       (countB),
    .running     (runningB),
    .zero        (zeroB),
    .done        (doneB)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against a hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of controls on the BCD instance; outputs are settled
  // 1 ns after the edge that sampled them.
  task automatic applyStimulus(input logic ld, input logic st, input logic sp,
                               input logic tk);
    load  = ld;
    start = st;
    stop  = sp;
    tick  = tk;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  // Same for the hex instance.
  task automatic applyStimulusHex(input logic ld, input logic st, input logic tk);
    loadB  = ld;
    startB = st;
    tickB  = tk;
    @(posedge clk);
    #1;
    loadB  = 1'b0;
    startB = 1'b0;
    tickB  = 1'b0;
  endtask

  // Directed sequence; every expected value below is worked out by hand.
  initial begin
    logic [11:0] expCount [6];
    logic        expDone  [6];

    checks   = 0;
    failures = 0;
    reset = 1'b1;
    tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; autoReload = 1'b0;
    preset = 12'h000;
    tickB = 1'b0; loadB = 1'b0; startB = 1'b0; stopB = 1'b0; autoReloadB = 1'b0;
    presetB = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(count), 32'h000);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;

    preset = 12'h042;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load042_count", 32'(count), 32'h042);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start042_running", 32'(running), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncrst_count", 32'(count), 32'h000);
    checkOutput("asyncrst_running", 32'(running), 32'd0);
    checkOutput("asyncrst_done", 32'(done), 32'd0);
    #1 reset = 1'b0;

    preset = 12'h100;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("borrow_count", 32'(count), 32'h099);
    checkOutput("borrow_running", 32'(running), 32'd1);

    autoReload = 1'b0;
    preset = 12'h003;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("oneshot_t1_count", 32'(count), 32'h002);
    checkOutput("oneshot_t1_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("oneshot_t2_count", 32'(count), 32'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("oneshot_t3_count", 32'(count), 32'h000);
    checkOutput("oneshot_t3_done", 32'(done), 32'd1);
    checkOutput("oneshot_t3_running", 32'(running), 32'd0);
    checkOutput("oneshot_t3_zero", 32'(zero), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("oneshot_donefall", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("expired_count", 32'(count), 32'h000);
    checkOutput("expired_running", 32'(running), 32'd0);
    checkOutput("expired_done", 32'(done), 32'd0);

    autoReload = 1'b1;
    preset = 12'h002;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    expCount = '{12'h001, 12'h002, 12'h001, 12'h002, 12'h001, 12'h002};
    expDone  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("reload_t%0d_count", i + 1), 32'(count), 32'(expCount[i]));
      checkOutput($sformatf("reload_t%0d_done", i + 1), 32'(done), 32'(expDone[i]));
      checkOutput($sformatf("reload_t%0d_zero", i + 1), 32'(zero), 32'd0);
    end
    checkOutput("reload_running", 32'(running), 32'd1);

    autoReload = 1'b0;
    preset = 12'h050;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stoptick_count", 32'(count), 32'h050);
    checkOutput("stoptick_running", 32'(running), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pausetick_count", 32'(count), 32'h050);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_running", 32'(running), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("resume_tick_count", 32'(count), 32'h049);
    preset = 12'h123;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("loadtick_count", 32'(count), 32'h123);
    checkOutput("loadtick_running", 32'(running), 32'd0);

    preset = 12'h000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("startzero_running", 32'(running), 32'd0);
    checkOutput("startzero_done", 32'(done), 32'd0);
    checkOutput("startzero_zero", 32'(zero), 32'd1);

    preset = 12'hC0C;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clamp_count", 32'(count), 32'h909);
    preset = 12'h0C5;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clamp_mid_count", 32'(count), 32'h095);

    presetB = 4'hF;
    applyStimulusHex(1'b1, 1'b0, 1'b0);
    applyStimulusHex(1'b0, 1'b1, 1'b0);
    applyStimulusHex(1'b0, 1'b0, 1'b1);
    checkOutput("hex_t1_count", 32'(countB), 32'hE);
    for (int i = 1; i < 15; i++) begin
      applyStimulusHex(1'b0, 1'b0, 1'b1);
    end
    checkOutput("hex_t15_count", 32'(countB), 32'h0);
    checkOutput("hex_t15_done", 32'(doneB), 32'd1);
    checkOutput("hex_t15_running", 32'(runningB), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
